// File: rtl/ks_div_pkg.sv
// Shared definitions for the iterative prefix-subtractor divider.
// Contents: FSM state encoding, default operand width, default counter width.
// No logic; imported by ks_trial_sub and ks_divider_16.
package ks_div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/ks_trial_sub.sv
// Combinational N-bit Kogge-Stone subtractor: diff = a - b, cout = 1 means no borrow.
// Latency: zero cycles (pure combinational, log2(N) black-dot levels).
// Backpressure: none; no handshake on this block.
// Ports: a, b (minuend, subtrahend), diff (a - b modulo 2^N), cout (carry-out).
module ks_trial_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         cout
);

    logic [N-1:0] g;    // per-bit generate of a + ~b
    logic [N-1:0] p;    // per-bit propagate of a + ~b
    logic [N-1:0] gg;   // running group generate
    logic [N-1:0] pp;   // running group propagate
    logic [N-1:0] gs;   // previous-level snapshot
    logic [N-1:0] ps;

    always_comb begin
        g  = a & ~b;
        p  = a ^ ~b;
        gg = g;
        pp = p;
        gs = '0;
        ps = '0;
        // Subtraction carries in a 1; fold it into bit 0's group generate
        // so every prefix G[i:0] already includes the carry-in.
        gg[0] = g[0] | p[0];
        for (int d = 1; d < N; d = d * 2) begin
            gs = gg;
            ps = pp;
            for (int i = 0; i < N; i++) begin
                if (i >= d) begin
                    gg[i] = gs[i] | (ps[i] & gs[i-d]);
                    pp[i] = ps[i] & ps[i-d];
                end
            end
        end
        // Carry into bit i is the group generate of bits below it;
        // carry into bit 0 is the injected 1.
        diff = p ^ {gg[N-2:0], 1'b1};
        cout = gg[N-1];
    end

endmodule

// File: rtl/ks_divider_16.sv
// Iterative unsigned restoring divider, one quotient bit per cycle via a WIDTH+1-bit prefix subtractor.
// Latency: WIDTH cycles from accept to Out_valid (1 cycle for a zero divisor when KS_DIV_ZERO_BYPASS_EN is defined).
// Backpressure: In_ready only in IDLE; result held frozen in DONE until Out_ready, any length of stall.
// Ports: clk, rst_n (async active-low), In_valid/In_ready + Dividend/Divisor in,
//        Out_valid/Out_ready + Quotient/Remainder/Div_by_zero out.
// Optional macro KS_DIV_ZERO_BYPASS_EN: zero divisor skips the CALC iterations.
module ks_divider_16
    import ks_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   q_reg;    // dividend shifts out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0]   r_reg;    // partial remainder
    logic [WIDTH-1:0]   d_reg;    // divisor
    logic               dbz_reg;

    logic [WIDTH:0]     trial_a;
    logic [WIDTH:0]     trial_b;
    logic [WIDTH:0]     trial_diff;
    logic               trial_cout;
    logic               unused_diff_msb;

    // The extra top bit keeps {R, next bit} exact even when R has its MSB set.
    assign trial_a         = {r_reg, q_reg[WIDTH-1]};
    assign trial_b         = {1'b0, d_reg};
    assign unused_diff_msb = trial_diff[WIDTH];   // always 0 when no borrow, since R < 2*Divisor

    ks_trial_sub #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a    (trial_a),
        .b    (trial_b),
        .diff (trial_diff),
        .cout (trial_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            d_reg   <= '0;
            dbz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_valid) begin
                        d_reg   <= Divisor;
                        cnt     <= '0;
                        dbz_reg <= (Divisor == '0);
`ifdef KS_DIV_ZERO_BYPASS_EN
                        if (Divisor == '0) begin
                            q_reg <= '1;
                            r_reg <= Dividend;
                            state <= DONE;
                        end else begin
                            q_reg <= Dividend;
                            r_reg <= '0;
                            state <= CALC;
                        end
`else
                        // A zero divisor never borrows, so the normal
                        // iterations yield all-ones quotient and R = Dividend.
                        q_reg <= Dividend;
                        r_reg <= '0;
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    q_reg <= {q_reg[WIDTH-2:0], trial_cout};
                    r_reg <= trial_cout ? trial_diff[WIDTH-1:0] : trial_a[WIDTH-1:0];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (Out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign In_ready    = rst_n && (state == IDLE);
    assign Out_valid   = (state == DONE);
    assign Quotient    = q_reg;
    assign Remainder   = r_reg;
    assign Div_by_zero = dbz_reg;

endmodule

// File: tb/tb_ks_divider_16.sv
// Scoreboard bench for ks_divider_16: driver pushes expected results computed with plain
// integer division, monitor pops and compares on each result, checking latency, hold
// under back-pressure, accept ordering and mid-operation reset.
module tb_ks_divider_16;

    localparam int W = 16;
`ifdef KS_DIV_ZERO_BYPASS_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = W;
`endif

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           acc;
        int           bp;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         In_valid;
    logic         In_ready;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Out_valid;
    logic         Out_ready = 1'b0;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Div_by_zero;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    int   seen      = 0;
    int   wait_left = 0;
    int   idle      = 0;
    int   last_take = 0;
    int   have_take = 0;

    ks_divider_16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Out_valid   (Out_valid),
        .Out_ready   (Out_ready),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_by_zero (Div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: plain integer arithmetic; zero divisor gives all ones / dividend.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int bp);
        exp_t e;
        if (b == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = ZLAT;
        end else begin
            e.q   = W'(int'(a) / int'(b));
            e.r   = W'(int'(a) % int'(b));
            e.dbz = 1'b0;
            e.lat = W;
        end
        e.bp  = bp;
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int bp, output int acc_o);
        exp_t e;
        int   waitc;
        waitc = 0;
        acc_o = 0;
        @(negedge clk);
        Dividend = a;
        Divisor  = b;
        In_valid = 1'b1;
        while (!In_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!In_ready) begin
            fail_now("accept_timeout");
            In_valid = 1'b0;
            return;
        end
        e     = model(a, b, bp);
        e.acc = cyc + 1;
        acc_o = e.acc;
        sb.push_back(e);
        if (have_take != 0) check("accept_after_take", 32'(e.acc > last_take), 32'd1);
        @(negedge clk);
        // Garbage on the operand bus must be ignored outside IDLE.
        In_valid = 1'b0;
        Dividend = W'($urandom);
        Divisor  = W'($urandom);
    endtask

    // Monitor: compares every cycle a result is presented, owns Out_ready.
    always begin
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            seen      = 0;
            idle      = 0;
            Out_ready = 1'b0;
        end else if (Out_valid) begin
            idle = 0;
            if (sb.size() == 0) begin
                fail_now("unexpected_result");
                Out_ready = 1'b1;
            end else begin
                e = sb[0];
                if (seen == 0) begin
                    seen      = 1;
                    wait_left = e.bp;
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                end
                check("quotient", 32'(Quotient), 32'(e.q));
                check("remainder", 32'(Remainder), 32'(e.r));
                check("div_by_zero", 32'(Div_by_zero), 32'(e.dbz));
                check("in_ready_low_in_done", 32'(In_ready), 32'd0);
                if (wait_left == 0) begin
                    Out_ready = 1'b1;
                    last_take = cyc + 1;
                    have_take = 1;
                    void'(sb.pop_front());
                    seen = 0;
                end else begin
                    Out_ready = 1'b0;
                    wait_left--;
                end
            end
        end else begin
            Out_ready = 1'b0;
            if (sb.size() != 0) begin
                idle++;
                if (idle > 100) begin
                    fail_now("result_timeout");
                    void'(sb.pop_front());
                    idle = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(In_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(Out_valid), 32'd0);
        check({tag, "_quotient"}, 32'(Quotient), 32'd0);
        check({tag, "_remainder"}, 32'(Remainder), 32'd0);
        check({tag, "_dbz"}, 32'(Div_by_zero), 32'd0);
    endtask

    initial begin
        int acc;
        int drain;
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n    = 1'b0;
        In_valid = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(In_ready), 32'd1);

        issue(16'd100, 16'd7, 0, acc);
        issue(16'hFFFF, 16'd1, 0, acc);
        issue(16'hFFFF, 16'hFFFF, 0, acc);
        issue(16'd3, 16'd10, 0, acc);
        issue(16'h8000, 16'h8001, 0, acc);
        issue(16'd5, 16'd0, 0, acc);
        issue(16'd1234, 16'd10, 5, acc);
        issue(16'd7, 16'd3, 0, acc);

        // Reset during CALC iteration 8: the in-flight result is discarded.
        issue(16'd40000, 16'd123, 0, acc);
        while (cyc < acc + 8) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(16'd50000, 16'd300, 0, acc);

        for (int i = 0; i < 40; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1, 2, 3: b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            issue(a, b, int'($urandom_range(0, 3)), acc);
        end

        drain = 0;
        while (sb.size() != 0 && drain < 500) begin
            @(negedge clk);
            drain++;
        end
        if (sb.size() != 0) fail_now("drain_timeout");
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        fail_now("global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ks_divider_16.md
# ks_divider_16

Iterative unsigned restoring divider that produces one quotient bit per clock. Each iteration uses a WIDTH+1-bit prefix (Kogge-Stone style) trial subtractor. The block consumes the same generate/propagate arithmetic as the team's parallel-prefix adders, but in the reverse direction: repeated subtraction instead of accumulation. It sits behind the datapath adders as the multi-cycle divide unit, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 16, operand, quotient and remainder width (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; asynchronous assert, active-low
- In_valid  input  1  operands valid
- In_ready  output  1  block can accept operands
- Dividend  input  WIDTH  unsigned dividend
- Divisor  input  WIDTH  unsigned divisor
- Out_valid  output  1  result valid
- Out_ready  input  1  consumer accepts result
- Quotient  output  WIDTH  floor(Dividend/Divisor)
- Remainder  output  WIDTH  Dividend mod Divisor
- Div_by_zero  output  1  Divisor was zero for this result

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - In_ready=1.
  - On In_valid&&In_ready, latch Dividend into the quotient/shift register and Divisor into the divisor register; clear the partial remainder R and the iteration counter.
  - Next state is CALC (see Configuration for divisor zero).
- CALC, per cycle (WIDTH cycles total, counter 0..WIDTH-1):
  - Trial = {R, next dividend MSB} (WIDTH+1 bits) minus {1'b0, Divisor}.
  - Carry-out = 1 (no borrow): R <= Trial[WIDTH-1:0] and shift in quotient bit 1.
  - Otherwise: R <= shifted value and shift in quotient bit 0.
  - After the iteration with counter = WIDTH-1, go to DONE.
- DONE:
  - Out_valid=1; Quotient, Remainder and Div_by_zero stable.
  - On Out_valid&&Out_ready, return to IDLE.
- In_ready=0 in CALC and DONE. Operands are never accepted in the same cycle a result is taken; the earliest new accept is the cycle after the result handshake.
- Divisor zero, either configuration: Quotient = all ones, Remainder = Dividend, Div_by_zero=1. Plain restoring produces these values naturally.
- Operand inputs are ignored outside IDLE.

## Timing
- Reset values: In_ready=0 while rst_n is low, then 1 in IDLE. Out_valid=0, Quotient=0, Remainder=0, Div_by_zero=0, state IDLE.
- Normal latency: accept on edge k; Out_valid is high after edge k+WIDTH (the 16th CALC edge for WIDTH=16).
- Out_valid holds, with all result outputs frozen, until Out_ready. Back-pressure of any length is legal.
- Reset asserted mid-CALC or mid-DONE: immediate return to IDLE with reset values; the in-flight result is discarded.
- Subtractor is combinational within one cycle; no multicycle paths.

## Configuration
- KS_DIV_ZERO_BYPASS_EN defined: Divisor==0 at accept goes IDLE→DONE on the next edge (1-cycle latency) with the divide-by-zero results.
- KS_DIV_ZERO_BYPASS_EN undefined: a zero divisor runs the full WIDTH CALC cycles and yields identical outputs. Div_by_zero is still flagged, from a comparison registered at accept.

## Structure
- Package ks_div_pkg contains:
  - state enum (IDLE, CALC, DONE)
  - default WIDTH constant
  - counter width constant $clog2(WIDTH)
- One sub-module: ks_trial_sub, a combinational WIDTH+1-bit prefix subtractor.
  - Built from per-bit g/p, black-dot prefix levels and a final sum XOR.
  - Outputs the difference and carry-out (1 = no borrow).
  - Instantiated once in ks_divider_16.

## Test plan
- 100/7, Out_ready=1 → Out_valid exactly 16 cycles after accept; Quotient=14, Remainder=2, Div_by_zero=0.
- 0xFFFF/1 and 0xFFFF/0xFFFF → Q=0xFFFF, R=0 and Q=1, R=0.
- 3/10 → Q=0, R=3; 0x8000/0x8001 → Q=0, R=0x8000 (exercises the WIDTH+1-bit trial).
- 5/0 → Q=0xFFFF, R=5, Div_by_zero=1.
  - With the macro: latency 1 cycle.
  - Without the macro: latency 16 cycles.
- Result 1234/10 with Out_ready low for 5 cycles → Out_valid and Q=123, R=4 held stable and In_ready=0 throughout. The next operand is accepted no earlier than the cycle after Out_ready rises.
- rst_n pulsed low at CALC iteration 8 → all outputs return to reset values immediately. The next division, 50000/300, completes correctly with Q=166, R=200.
